// File: rtl/button_conditioner.sv
// Per-button synchroniser and debounce FSM.
// Each channel emits a clean level plus one-cycle press/release pulses.
module button_conditioner #(
  parameter int NUM_BUTTONS = 2,
  parameter int CLK_PER     = 10,
  parameter int DEBOUNCE_US = 5000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   CPU_RESETN,
  input  logic [NUM_BUTTONS-1:0] btn_in,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release
);

  localparam int DB_CYCLES = (DEBOUNCE_US * 1000) / CLK_PER;
  localparam int CW = $clog2(DB_CYCLES + 1);

  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  if (DB_CYCLES < 1) begin : g_bad_db
    $error("button_conditioner: DB_CYCLES must be nonzero");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("button_conditioner: SYNC_STAGES must be 2..4");
  end

  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   rel_q, rel_d;
    logic                   s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_in[i]};
    assign s      = sync_q[SYNC_STAGES-1];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      unique case (state_q)
        IDLE_LOW: begin
          if (s) begin
            state_d = WAIT_HIGH;
            cnt_d   = '0;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state_d = IDLE_LOW;
          end else if (cnt_q == CNT_MAX) begin
            state_d = IDLE_HIGH;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        IDLE_HIGH: begin
          if (!s) begin
            state_d = WAIT_LOW;
            cnt_d   = '0;
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state_d = IDLE_HIGH;
          end else if (cnt_q == CNT_MAX) begin
            state_d = IDLE_LOW;
            level_d = 1'b0;
            rel_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
        sync_q  <= '0;
        state_q <= IDLE_LOW;
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = rel_q;
  end

endmodule
